// File: rtl/ether_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : ether_hdr_parser
// Brief    : Extracts Ethernet/IPv4 fields from a 32-bit frame stream and
//            reports frame length and short/runt errors at end of frame.
// Revision : 1.0
// ============================================================================
module ether_hdr_parser #(
    parameter int MIN_FRAME_WORDS = 16,
    parameter int LEN_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_rxd_tdata,
    input  logic             i_rxd_tvalid,
    input  logic             i_rxd_tlast,
    output logic [47:0]      o_dst_mac,
    output logic [47:0]      o_src_mac,
    output logic [15:0]      o_ethertype,
    output logic [7:0]       o_ip_ttl,
    output logic [7:0]       o_ip_proto,
    output logic [31:0]      o_src_ip,
    output logic [31:0]      o_dst_ip,
    output logic             o_is_ipv4,
    output logic             o_is_tcp,
    output logic             o_hdr_valid,
    output logic             o_frame_done,
    output logic [LEN_W-1:0] o_frame_len,
    output logic             o_err_short,
    output logic             o_err_runt
);

    typedef enum logic [0:0] {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] C_CNT_MAX      = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] C_MIN_WORDS    = LEN_W'(MIN_FRAME_WORDS);
    localparam logic [3:0]       C_LAST_HDR_IDX = 4'd8;

    state_t           r_state;
    state_t           w_state_nx;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nx;
    logic [LEN_W-1:0] r_wcnt;
    logic [LEN_W-1:0] w_len;
    logic             w_hdr_done;
    logic             w_short;
    logic             w_frame_end;

    logic [47:0]      r_sh_dst;
    logic [47:0]      r_sh_src;
    logic [15:0]      r_sh_eth;
    logic [7:0]       r_sh_ttl;
    logic [7:0]       r_sh_proto;
    logic [31:0]      r_sh_sip;
    logic [15:0]      r_sh_dip_hi;

    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_hdr_done  = 1'b0;
        w_short     = 1'b0;
        w_frame_end = i_rxd_tvalid && i_rxd_tlast;
        w_len       = (r_wcnt == C_CNT_MAX) ? C_CNT_MAX : r_wcnt + LEN_W'(1);
        if (i_rxd_tvalid) begin
            case (r_state)
                S_HDR: begin
                    if (r_idx == C_LAST_HDR_IDX) begin
                        w_hdr_done = 1'b1;
                        w_idx_nx   = 4'd0;
                        w_state_nx = i_rxd_tlast ? S_HDR : S_BODY;
                    end else if (i_rxd_tlast) begin
                        w_short  = 1'b1;
                        w_idx_nx = 4'd0;
                    end else begin
                        w_idx_nx = r_idx + 4'd1;
                    end
                end
                S_BODY: begin
                    if (i_rxd_tlast) begin
                        w_state_nx = S_HDR;
                    end
                end
                default: w_state_nx = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HDR;
            r_idx   <= 4'd0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            // Clearing on the tlast beat makes the next frame's first beat count as 1.
            if (i_rxd_tvalid) begin
                r_wcnt <= w_frame_end ? '0 : w_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_dst    <= '0;
            r_sh_src    <= '0;
            r_sh_eth    <= '0;
            r_sh_ttl    <= '0;
            r_sh_proto  <= '0;
            r_sh_sip    <= '0;
            r_sh_dip_hi <= '0;
        end else if (i_rxd_tvalid && r_state == S_HDR) begin
            case (r_idx)
                4'd0: r_sh_dst[47:16] <= i_rxd_tdata;
                4'd1: begin
                    r_sh_dst[15:0]  <= i_rxd_tdata[31:16];
                    r_sh_src[47:32] <= i_rxd_tdata[15:0];
                end
                4'd2: r_sh_src[31:0] <= i_rxd_tdata;
                4'd3: r_sh_eth <= i_rxd_tdata[31:16];
                4'd5: begin
                    r_sh_ttl   <= i_rxd_tdata[15:8];
                    r_sh_proto <= i_rxd_tdata[7:0];
                end
                4'd6: r_sh_sip[31:16] <= i_rxd_tdata[15:0];
                4'd7: begin
                    r_sh_sip[15:0] <= i_rxd_tdata[31:16];
                    r_sh_dip_hi    <= i_rxd_tdata[15:0];
                end
                default: ;
            endcase
        end
    end

    // Word 8 is published straight from the bus so fields appear one cycle after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_dst_mac    <= '0;
            o_src_mac    <= '0;
            o_ethertype  <= '0;
            o_ip_ttl     <= '0;
            o_ip_proto   <= '0;
            o_src_ip     <= '0;
            o_dst_ip     <= '0;
            o_is_ipv4    <= 1'b0;
            o_is_tcp     <= 1'b0;
            o_hdr_valid  <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_len  <= '0;
            o_err_short  <= 1'b0;
            o_err_runt   <= 1'b0;
        end else begin
            o_hdr_valid  <= w_hdr_done;
            o_frame_done <= w_frame_end;
            o_err_short  <= w_short;
            o_err_runt   <= w_frame_end && (w_len < C_MIN_WORDS);
            if (w_hdr_done) begin
                o_dst_mac   <= r_sh_dst;
                o_src_mac   <= r_sh_src;
                o_ethertype <= r_sh_eth;
                o_ip_ttl    <= r_sh_ttl;
                o_ip_proto  <= r_sh_proto;
                o_src_ip    <= r_sh_sip;
                o_dst_ip    <= {r_sh_dip_hi, i_rxd_tdata[31:16]};
                o_is_ipv4   <= (r_sh_eth == 16'h0800);
                o_is_tcp    <= (r_sh_eth == 16'h0800) && (r_sh_proto == 8'h06);
            end
            if (w_frame_end) begin
                o_frame_len <= w_len;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ether_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ether_hdr_parser
// Brief    : Table-driven frame stimulus with a queue scoreboard for headers
//            and frame-end reports, plus reset-mid-frame sequence.
// Revision : 1.0
// ============================================================================
module tb_ether_hdr_parser;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] eth;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
        logic        is4;
        logic        tcp;
    } hdr_t;

    typedef struct {
        hdr_t h;
        int   cyc;
    } hdr_exp_t;

    typedef struct {
        logic [15:0] len;
        logic        sh;
        logic        runt;
        int          cyc;
    } end_exp_t;

    typedef struct {
        logic [8:0][31:0] w;
        int               len;
        int               gap4;
        int               gapp;
        bit               exp_hdr;
        bit               exp_short;
        bit               exp_runt;
        hdr_t             h;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [47:0] o_dst_mac, o_src_mac;
    logic [15:0] o_ethertype;
    logic [7:0]  o_ip_ttl, o_ip_proto;
    logic [31:0] o_src_ip, o_dst_ip;
    logic        o_is_ipv4, o_is_tcp, o_hdr_valid, o_frame_done;
    logic [15:0] o_frame_len;
    logic        o_err_short, o_err_runt;

    int total = 0;
    int bad = 0;
    int edges = 0;
    hdr_exp_t hdr_q[$];
    end_exp_t end_q[$];
    hdr_t     last_hdr = '0;
    logic [31:0] nom [9];
    vec_t vecs [8];

    ether_hdr_parser #(.MIN_FRAME_WORDS(16), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_rxd_tdata(tdata), .i_rxd_tvalid(tvalid), .i_rxd_tlast(tlast),
        .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_ethertype(o_ethertype),
        .o_ip_ttl(o_ip_ttl), .o_ip_proto(o_ip_proto),
        .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip),
        .o_is_ipv4(o_is_ipv4), .o_is_tcp(o_is_tcp),
        .o_hdr_valid(o_hdr_valid), .o_frame_done(o_frame_done),
        .o_frame_len(o_frame_len), .o_err_short(o_err_short), .o_err_runt(o_err_runt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at edge %0d", name, got, want, edges);
        end
    endtask

    function automatic hdr_t outs();
        hdr_t o;
        o = '{dst: o_dst_mac, src: o_src_mac, eth: o_ethertype, ttl: o_ip_ttl,
              proto: o_ip_proto, sip: o_src_ip, dip: o_dst_ip,
              is4: o_is_ipv4, tcp: o_is_tcp};
        return o;
    endfunction

    // Scoreboard: compares registered outputs away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_zero", 256'({outs(), o_hdr_valid, o_frame_done, o_frame_len,
                                    o_err_short, o_err_runt}), 256'(0));
            last_hdr = '0;
        end else begin
            if (o_hdr_valid) begin
                if (hdr_q.size() == 0) begin
                    chk("hdr_unexpected", 256'(1), 256'(0));
                end else begin
                    hdr_exp_t e;
                    e = hdr_q.pop_front();
                    chk("hdr_fields", 256'(outs()), 256'(e.h));
                    chk("hdr_latency", 256'(edges), 256'(e.cyc));
                    last_hdr = e.h;
                end
            end else begin
                chk("fields_hold", 256'(outs()), 256'(last_hdr));
            end
            if (o_frame_done) begin
                if (end_q.size() == 0) begin
                    chk("done_unexpected", 256'(1), 256'(0));
                end else begin
                    end_exp_t f;
                    f = end_q.pop_front();
                    chk("frame_end", 256'({o_frame_len, o_err_short, o_err_runt, edges}),
                        256'({f.len, f.sh, f.runt, f.cyc}));
                end
            end else begin
                chk("err_without_done", 256'({o_err_short, o_err_runt}), 256'(0));
            end
        end
    end

    task automatic drive(input bit v, input bit l, input logic [31:0] d);
        @(posedge clk);
        #1;
        tvalid = v;
        tlast  = l;
        tdata  = d;
    endtask

    task automatic send_frame(input vec_t v);
        logic [31:0] d;
        bit l;
        for (int b = 0; b < v.len; b++) begin
            if (b == 5 && v.gap4 > 0) repeat (v.gap4) drive(1'b0, 1'b0, 32'hxxxx_xxxx);
            if (b == 50 && v.gapp > 0) repeat (v.gapp) drive(1'b0, 1'b1, 32'hxxxx_xxxx);
            if (b < 9) d = v.w[b];
            else d = $urandom;
            l = (b == v.len - 1);
            drive(1'b1, l, d);
            if (b == 8 && v.exp_hdr) hdr_q.push_back('{h: v.h, cyc: edges + 1});
            if (l) end_q.push_back('{len: 16'(v.len), sh: v.exp_short,
                                     runt: v.exp_runt, cyc: edges + 1});
        end
    endtask

    function automatic vec_t mk(input int len, input bit eh, input bit es, input bit er,
                                input hdr_t h);
        vec_t v;
        for (int i = 0; i < 9; i++) v.w[i] = nom[i];
        v.len = len; v.gap4 = 0; v.gapp = 0;
        v.exp_hdr = eh; v.exp_short = es; v.exp_runt = er; v.h = h;
        return v;
    endfunction

    initial begin
        hdr_t hn, hv6, hudp;
        vec_t v;
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", edges);
        $fatal(1);
        hn = '0; hv6 = '0; hudp = '0; v = vecs[0];
    end

    initial begin
        hdr_t hn, hv6, hudp;
        vec_t v;
        nom = '{32'h8000_207A, 32'h3F3E_8000, 32'h2020_3AAE, 32'h0800_AAAA, 32'hBBBB_BBBB,
                32'hCCCC_9906, 32'hDDDD_DDDD, 32'hFFFF_BAAA, 32'hBBBB_CCCC};
        hn   = '{dst: 48'h8000_207A_3F3E, src: 48'h8000_2020_3AAE, eth: 16'h0800,
                 ttl: 8'h99, proto: 8'h06, sip: 32'hDDDD_FFFF, dip: 32'hBAAA_BBBB,
                 is4: 1'b1, tcp: 1'b1};
        hv6  = hn; hv6.eth = 16'h86DD; hv6.is4 = 1'b0; hv6.tcp = 1'b0;
        hudp = hn; hudp.ttl = 8'h40; hudp.proto = 8'h11; hudp.tcp = 1'b0;

        vecs[0] = mk(100, 1, 0, 0, hn);
        vecs[1] = mk(100, 1, 0, 0, hn);  vecs[1].gap4 = 3; vecs[1].gapp = 50;
        vecs[2] = mk(6,   0, 1, 1, hn);
        vecs[3] = mk(9,   1, 0, 1, hn);
        vecs[4] = mk(9,   1, 0, 1, hv6); vecs[4].w[3] = 32'h86DD_0000;
        vecs[5] = mk(16,  1, 0, 0, hudp); vecs[5].w[5] = 32'h0000_4011;
        vecs[6] = mk(15,  1, 0, 1, hudp); vecs[6].w[5] = 32'h0000_4011;
        vecs[7] = mk(1,   0, 1, 1, hn);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 32'h0);

        // Frames in the table are sent back to back with no idle beats between them.
        foreach (vecs[i]) send_frame(vecs[i]);
        repeat (4) drive(1'b0, 1'b0, 32'h0);

        // Back-to-back: IPv6-typed header, then nominal, w0 right after tlast.
        send_frame(vecs[4]);
        v = vecs[0]; v.len = 20;
        send_frame(v);
        repeat (3) drive(1'b0, 1'b0, 32'h0);

        // Reset during w6, then a fresh nominal frame.
        for (int b = 0; b < 6; b++) drive(1'b1, 1'b0, nom[b]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        v = vecs[0]; v.len = 24;
        send_frame(v);
        repeat (5) drive(1'b0, 1'b0, 32'h0);

        chk("hdr_q_drained", 256'(hdr_q.size()), 256'(0));
        chk("end_q_drained", 256'(end_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
